// File: rtl/sig_qual_pkg.sv
// Shared types and helpers for the sig_qualifier channel debouncer.
package sig_qual_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    VALID = 2'd2,
    HOLD  = 2'd3
  } chan_state_e;

  localparam int DEF_CNT_W = 4;

  // A programmed threshold of zero behaves like one: a single sample qualifies.
  function automatic logic [31:0] eff_thr(input logic [31:0] x);
    return (x == 32'd0) ? 32'd1 : x;
  endfunction

endpackage

// File: rtl/sig_qual_chan.sv
// One qualifier channel: 4-state debounce FSM with saturating run counter,
// registered valid copy for rise/fall edge pulses.
module sig_qual_chan
  import sig_qual_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             s,
  input  logic [CNT_W-1:0] on_thresh,
  input  logic [CNT_W-1:0] off_thresh,
  output logic             valid,
  output logic             rise,
  output logic             fall
);

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_d_q;

  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W-1:0] cnt_sat;
  logic [31:0]      inc_ext;
  logic [31:0]      on_thr;
  logic [31:0]      off_thr;

  always_comb begin
    on_thr  = eff_thr(32'(on_thresh));
    off_thr = eff_thr(32'(off_thresh));
    // Increment one bit wider so the threshold compare never sees a wrapped count.
    cnt_inc = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(1);
    inc_ext = 32'(cnt_inc);
    cnt_sat = cnt_inc[CNT_W] ? {CNT_W{1'b1}} : cnt_inc[CNT_W-1:0];

    state_d = state_q;
    cnt_d   = cnt_q;

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s) begin
            if (inc_ext >= on_thr) begin
              state_d = VALID;
              cnt_d   = '0;
            end else begin
              state_d = COUNT;
              cnt_d   = CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        COUNT: begin
          if (s) begin
            if (inc_ext >= on_thr) begin
              state_d = VALID;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_sat;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        VALID: begin
          if (s) begin
            cnt_d = '0;
          end else if (off_thr <= 32'd1) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = HOLD;
            cnt_d   = CNT_W'(1);
          end
        end
        HOLD: begin
          if (s) begin
            state_d = VALID;
            cnt_d   = '0;
          end else if (inc_ext >= off_thr) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_sat;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      valid_d_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_d_q <= valid;
    end
  end

  // Decoded from registered state only, so sig never reaches the outputs combinationally.
  assign valid = (state_q == VALID) || (state_q == HOLD);
  assign rise  = valid & ~valid_d_q;
  assign fall  = ~valid & valid_d_q;

endmodule

// File: rtl/sig_qualifier.sv
// N-channel signal qualifier with shared thresholds and enable.
// Define SIG_QUAL_SYNC_EN to insert a 2-flop synchronizer on every sig bit (+2 cycles latency).
module sig_qualifier
  import sig_qual_pkg::*;
#(
  parameter int N     = 1,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N-1:0]     sig,
  input  logic [CNT_W-1:0] on_thresh,
  input  logic [CNT_W-1:0] off_thresh,
  output logic [N-1:0]     valid,
  output logic [N-1:0]     rise,
  output logic [N-1:0]     fall
);

  logic [N-1:0] sig_s;

`ifdef SIG_QUAL_SYNC_EN
  logic [N-1:0] sync1_q;
  logic [N-1:0] sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sig;
      sync2_q <= sync1_q;
    end
  end

  assign sig_s = sync2_q;
`else
  assign sig_s = sig;
`endif

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      sig_qual_chan #(
        .CNT_W(CNT_W)
      ) u_chan (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .s         (sig_s[gi]),
        .on_thresh (on_thresh),
        .off_thresh(off_thresh),
        .valid     (valid[gi]),
        .rise      (rise[gi]),
        .fall      (fall[gi])
      );
    end
  endgenerate

endmodule
